ram_burst_ctrl: RTL and testbench

Burst request sequencer that sits directly upstream of the single-port RAM and drives its valid/ready, write-enable, read-enable, address and write-data pins. It accepts one command per burst: start address, beat count and direction. It streams write beats in from a producer with flow control, and streams read beats out with valid/last markers. It owns the RAM handshake: raising valid, waiting for ready, issuing one beat per cycle, then releasing valid and waiting for ready to drop before accepting the next command.

---
 rtl/ram_burst_ctrl.sv | 120 ++++++++++++
 tb/tb_ram_burst_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer in front of a single-port RAM.
// One command per burst; owns the RAM valid/ready handshake.
module ram_burst_ctrl #(
  parameter int MEM_DEPTH  = 128,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_last_o,
  output logic                  done_o,
  output logic                  ram_valid_o,
  input  logic                  ram_ready_i,
  output logic                  ram_wr_en_o,
  output logic                  ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    XFER,
    RELEASE
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         cnt_q;
  logic                  done_q;
  logic                  rv1_q, rl1_q;
  logic                  accept, issue, last;

  assign accept = cmd_valid_i & (state_q == IDLE);
  assign issue  = (state_q == XFER) & ram_ready_i
                & (~wr_q | wdata_valid_i);
  assign last   = (cnt_q == CW'(1));

  assign done_o        = done_q;
  assign ram_addr_o    = addr_q;
  assign ram_wr_data_o = wdata_i;

  always_comb begin
    state_d       = state_q;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    ram_valid_o   = 1'b0;
    ram_wr_en_o   = 1'b0;
    ram_rd_en_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = ARM;
      end
      ARM: begin
        ram_valid_o = 1'b1;
        if (ram_ready_i) state_d = XFER;
      end
      XFER: begin
        ram_valid_o   = 1'b1;
        wdata_ready_o = wr_q & ram_ready_i;
        ram_wr_en_o   = wr_q & wdata_valid_i & ram_ready_i;
        ram_rd_en_o   = ~wr_q & ram_ready_i;
        if (issue && last) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ram_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      rv1_q         <= 1'b0;
      rl1_q         <= 1'b0;
      rdata_valid_o <= 1'b0;
      rdata_last_o  <= 1'b0;
      rdata_o       <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == RELEASE) & ~ram_ready_i;
      if (accept) begin
        wr_q   <= cmd_wr_i;
        addr_q <= cmd_addr_i;
        cnt_q  <= {1'b0, cmd_len_i} + CW'(1);
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        cnt_q  <= cnt_q - CW'(1);
      end
      // RAM data lands one cycle after issue; register it once more
      rv1_q         <= issue & ~wr_q;
      rl1_q         <= issue & ~wr_q & last;
      rdata_valid_o <= rv1_q;
      rdata_last_o  <= rl1_q;
      if (rv1_q) rdata_o <= ram_rd_data_i;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural RAM
// and write/read scoreboards.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_wr = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready_o;
  logic [7:0] wdata = '0;
  logic       rdata_valid_o;
  logic [7:0] rdata_o;
  logic       rdata_last_o;
  logic       done_o;
  logic       ram_valid_o;
  logic       ram_ready;
  logic       ram_wr_en_o;
  logic       ram_rd_en_o;
  logic [6:0] ram_addr_o;
  logic [7:0] ram_wr_data_o;
  logic [7:0] ram_rd_data;

  ram_burst_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_wr_i      (cmd_wr),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .wdata_valid_i (wdata_valid),
    .wdata_ready_o (wdata_ready_o),
    .wdata_i       (wdata),
    .rdata_valid_o (rdata_valid_o),
    .rdata_o       (rdata_o),
    .rdata_last_o  (rdata_last_o),
    .done_o        (done_o),
    .ram_valid_o   (ram_valid_o),
    .ram_ready_i   (ram_ready),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_rd_en_o   (ram_rd_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_wr_data_o (ram_wr_data_o),
    .ram_rd_data_i (ram_rd_data)
  );

  always #5 clk = ~clk;

  // RAM: ready follows valid by one cycle, registered read
  logic [7:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = 8'h00;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ram_ready <= 1'b0;
    else        ram_ready <= ram_valid_o;

  always @(posedge clk) begin
    if (ram_valid_o && ram_ready && ram_wr_en_o)
      mem[ram_addr_o] <= ram_wr_data_o;
    if (ram_valid_o && ram_ready && ram_rd_en_o)
      ram_rd_data <= mem[ram_addr_o];
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [14:0] exp_wr [$];
  logic [8:0]  exp_rd [$];
  logic [7:0]  sb_mem [128];

  int first_wr = -1, last_wr_cyc = 0;
  int first_rd = -1, last_rd_cyc = 0;
  int done_cyc = 0, done_cnt = 0;
  int acc_cyc = 0, acc_cnt = 0;
  logic both_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wr_en_o && ram_rd_en_o) both_en = 1'b1;
      if (ram_wr_en_o) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0)
          check("wr_spurious", exp_wr.size(), 1);
        else
          check("wr_beat", {ram_addr_o, ram_wr_data_o},
                exp_wr.pop_front());
      end
      if (rdata_valid_o) begin
        if (first_rd < 0) first_rd = cyc;
        if (rdata_last_o) last_rd_cyc = cyc;
        if (exp_rd.size() == 0)
          check("rd_spurious", exp_rd.size(), 1);
        else
          check("rd_beat", {rdata_last_o, rdata_o},
                exp_rd.pop_front());
      end
      if (done_o) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (cmd_valid && cmd_ready_o) begin
        acc_cyc = cyc;
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr,
                          input logic [6:0] a,
                          input logic [3:0] l);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready_o && t < 100) begin
      step();
      t++;
    end
    check("cmd_accept", cmd_ready_o, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (done_cnt == n0 && t < 200) begin
      step();
      t++;
    end
    check("done_seen", done_cnt, n0 + 1);
  endtask

  task automatic wr_data(input logic [6:0] a, input int l,
                         input logic [7:0] base, input int stall_at);
    int i = 0, t = 0, stall = 0;
    logic [6:0] ad;
    while (i <= l && t < 200) begin
      if (stall > 0) begin
        wdata_valid = 1'b0;
        if (wdata_ready_o) begin
          stall--;
          #1 check("stall_no_wr", ram_wr_en_o, 0);
        end
      end else begin
        wdata_valid = 1'b1;
        wdata = base + 8'(i);
        if (wdata_ready_o) begin
          ad = a + 7'(i);
          exp_wr.push_back({ad, wdata});
          sb_mem[ad] = wdata;
          if (i == stall_at) stall = 2;
          i++;
        end
      end
      step();
      t++;
    end
    wdata_valid = 1'b0;
    check("wr_beats_sent", i, l + 1);
  endtask

  task automatic push_rd(input logic [6:0] a, input int l);
    logic [6:0] ad;
    for (int i = 0; i <= l; i++) begin
      ad = a + 7'(i);
      exp_rd.push_back({i == l, sb_mem[ad]});
    end
  endtask

  task automatic wr_burst(input logic [6:0] a, input int l,
                          input logic [7:0] base, input int stall_at);
    int n0 = done_cnt;
    first_wr = -1;
    send_cmd(1'b1, a, 4'(l));
    wr_data(a, l, base, stall_at);
    wait_done(n0);
    check("wr_done_lat", done_cyc - last_wr_cyc, 3);
    if (stall_at < 0)
      check("wr_span", last_wr_cyc - first_wr, l);
    else
      check("wr_stall_span", last_wr_cyc - first_wr, l + 2);
    check("wr_sb_empty", exp_wr.size(), 0);
  endtask

  task automatic rd_burst(input logic [6:0] a, input int l);
    int n0 = done_cnt;
    first_rd = -1;
    push_rd(a, l);
    send_cmd(1'b0, a, 4'(l));
    wait_done(n0);
    check("rd_done_lat", done_cyc - last_rd_cyc, 1);
    check("rd_span", last_rd_cyc - first_rd, l);
    check("rd_sb_empty", exp_rd.size(), 0);
  endtask

  initial begin
    int n0, a0;
    for (int i = 0; i < 128; i++) sb_mem[i] = 8'h00;

    #3;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_wdata_ready", wdata_ready_o, 0);
    check("rst_rvalid", rdata_valid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_rlast", rdata_last_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ram_ctl",
          {ram_valid_o, ram_wr_en_o, ram_rd_en_o}, 0);
    check("rst_ram_addr", ram_addr_o, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_cmd_ready", cmd_ready_o, 1);

    wr_burst(7'd10, 3, 8'hA0, -1);
    rd_burst(7'd10, 3);

    wr_burst(7'd126, 3, 8'hB0, -1);
    rd_burst(7'd126, 3);

    wr_burst(7'd40, 3, 8'hC0, 1);
    rd_burst(7'd40, 3);

    // second command held while a write burst runs
    n0 = done_cnt;
    a0 = acc_cnt;
    first_wr = -1;
    send_cmd(1'b1, 7'd20, 4'd3);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = 7'd20;
    cmd_len   = 4'd3;
    wr_data(7'd20, 3, 8'hD0, -1);
    first_rd = -1;
    push_rd(7'd20, 3);
    check("busy_held", acc_cnt, a0 + 1);
    wait_done(n0);
    cmd_valid = 1'b0;
    check("busy_acc_cnt", acc_cnt, a0 + 2);
    check("busy_acc_at_done", acc_cyc, done_cyc);
    wait_done(n0 + 1);
    check("busy_rd_done_lat", done_cyc - last_rd_cyc, 1);
    check("busy_rd_sb_empty", exp_rd.size(), 0);

    // reset asserted in the middle of a long read
    push_rd(7'd0, 15);
    send_cmd(1'b0, 7'd0, 4'd15);
    repeat (6) step();
    check("pre_rst_in_burst", ram_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ram_valid", ram_valid_o, 0);
    check("mid_rst_rd_en", ram_rd_en_o, 0);
    check("mid_rst_cmd_ready", cmd_ready_o, 1);
    check("mid_rst_rvalid", rdata_valid_o, 0);
    exp_rd.delete();
    n0 = done_cnt;
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("no_done_after_rst", done_cnt, n0);
    check("post_rst_idle", cmd_ready_o, 1);
    rd_burst(7'd10, 3);

    check("no_rd_wr_overlap", both_en, 0);
    check("wr_sb_final", exp_wr.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
